// File: rtl/lib_allocator_islip_scheduler.sv
// iSLIP separable NxM allocator: per-output round-robin grant, per-input round-robin accept, iterated.
// Latency: i_start -> o_valid after ITERATIONS+1 cycles; the next start is taken one cycle after o_valid.
// Backpressure: none; i_start is honoured only in IDLE and is dropped (not queued) while busy.
// Option macro LIB_ALLOCATOR_EARLY_EXIT_EN: finish once an iteration adds no pair or one side is fully matched.
module lib_allocator_islip_scheduler #(
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int ITERATIONS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [N-1:0][M-1:0] i_request,  // [i][j]: input i has a cell for output j
  output logic [M-1:0][N-1:0] o_grant,    // [j][i]: output j matched to input i
  output logic                o_valid,
  output logic                o_busy
);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [N-1:0][M-1:0]  req_q, req_d;
  logic [M-1:0][N-1:0]  match_q, match_d;
  logic [M-1:0][N-1:0]  grant_q, grant_d;
  logic [M-1:0][NW-1:0] g_q, g_d;
  logic [N-1:0][MW-1:0] a_q, a_d;

  logic [N-1:0]         in_matched;
  logic [M-1:0]         out_matched;
  logic [M-1:0][N-1:0]  gnt;
  logic [M-1:0][N-1:0]  acc;
  logic [M-1:0][N-1:0]  match_nx;
  logic [M-1:0]         g_found;
  logic [N-1:0]         a_found;
  logic                 iter_last;

  // Inputs and outputs that already own a pair are frozen for the rest of the matching
  always_comb begin
    in_matched  = '0;
    out_matched = '0;
    for (int j = 0; j < M; j++) begin
      out_matched[j] = |match_q[j];
      for (int i = 0; i < N; i++) begin
        if (match_q[j][i]) in_matched[i] = 1'b1;
      end
    end
  end

  // Grant: each free output picks the first eligible input at or after its pointer
  always_comb begin : grant_stage
    int idx;
    idx     = 0;
    gnt     = '0;
    g_found = '0;
    for (int j = 0; j < M; j++) begin
      for (int off = 0; off < N; off++) begin
        idx = (int'(g_q[j]) + off) % N;
        if (!g_found[j] && !out_matched[j] && req_q[idx][j] && !in_matched[idx]) begin
          gnt[j][idx] = 1'b1;
          g_found[j]  = 1'b1;
        end
      end
    end
  end

  // Accept: each input takes the first granting output at or after its pointer
  always_comb begin : accept_stage
    int idx;
    idx     = 0;
    acc     = '0;
    a_found = '0;
    for (int i = 0; i < N; i++) begin
      for (int off = 0; off < M; off++) begin
        idx = (int'(a_q[i]) + off) % M;
        if (!a_found[i] && gnt[idx][i]) begin
          acc[idx][i] = 1'b1;
          a_found[i]  = 1'b1;
        end
      end
    end
  end

  assign match_nx = match_q | acc;

  // Decide whether this ITER cycle is the final one of the matching
`ifdef LIB_ALLOCATOR_EARLY_EXIT_EN
  logic [N-1:0] in_cov;
  logic [M-1:0] out_cov;
  always_comb begin
    iter_last = (k_q == KW'(ITERATIONS - 1));
    in_cov    = '0;
    out_cov   = '0;
    for (int j = 0; j < M; j++) begin
      out_cov[j] = |match_nx[j];
      for (int i = 0; i < N; i++) begin
        if (match_nx[j][i]) in_cov[i] = 1'b1;
      end
    end
    if ((acc == '0) || (&in_cov) || (&out_cov)) iter_last = 1'b1;
  end
`else
  always_comb begin
    iter_last = (k_q == KW'(ITERATIONS - 1));
  end
`endif

  // FSM next state, request capture, match accumulation and first-iteration pointer moves
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    req_d   = req_q;
    match_d = match_q;
    grant_d = grant_q;
    g_d     = g_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_ITER;
          k_d     = '0;
          req_d   = i_request;
          match_d = '0;
        end
      end
      S_ITER: begin
        match_d = match_nx;
        // Only first-iteration accepts move pointers; this is what desynchronises them
        if (k_q == '0) begin
          for (int j = 0; j < M; j++) begin
            for (int i = 0; i < N; i++) begin
              if (acc[j][i]) begin
                g_d[j] = (i == N - 1) ? '0 : NW'(i + 1);
                a_d[i] = (j == M - 1) ? '0 : MW'(j + 1);
              end
            end
          end
        end
        if (iter_last) begin
          state_d = S_DONE;
          grant_d = match_nx;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any matching in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      req_q   <= '0;
      match_q <= '0;
      grant_q <= '0;
      g_q     <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      req_q   <= req_d;
      match_q <= match_d;
      grant_q <= grant_d;
      g_q     <= g_d;
      a_q     <= a_d;
    end
  end

  assign o_grant = grant_q;
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_lib_allocator_islip_scheduler.sv
// Bench for the iSLIP allocator: scoreboard of expected matchings and latencies from a reference model.
`timescale 1ns/1ps
module tb_lib_allocator_islip_scheduler;
  localparam int N = 4;
  localparam int M = 4;
  localparam int ITERS = 2;
  typedef logic [3:0][3:0] mat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_start = 1'b0;
  mat_t i_request = '0;
  mat_t o_grant;
  logic o_valid, o_busy;

  int n_cmp = 0;
  int n_err = 0;
  mat_t exp_q[$];
  int   lat_q[$];
  int   m_g[4];
  int   m_a[4];

  always #5 clk = ~clk;

  lib_allocator_islip_scheduler #(.N(N), .M(M), .ITERATIONS(ITERS)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_request(i_request),
    .o_grant(o_grant), .o_valid(o_valid), .o_busy(o_busy)
  );

  // Reference iSLIP: req[i][j], result[j][i]; pointers move only on first-iteration accepts
  task automatic model_match(input mat_t req, output mat_t res, output int lat);
    mat_t gn, ac;
    bit im[4];
    bit om[4];
    bit fnd, alli, allo;
    int idx;
    res = '0;
    lat = ITERS + 1;
    for (int k = 0; k < ITERS; k++) begin
      for (int x = 0; x < 4; x++) begin im[x] = 0; om[x] = 0; end
      for (int j = 0; j < M; j++)
        for (int i = 0; i < N; i++)
          if (res[j][i]) begin im[i] = 1; om[j] = 1; end
      gn = '0;
      for (int j = 0; j < M; j++) begin
        fnd = 0;
        for (int off = 0; off < N; off++) begin
          idx = (m_g[j] + off) % N;
          if (!fnd && !om[j] && req[idx][j] && !im[idx]) begin gn[j][idx] = 1; fnd = 1; end
        end
      end
      ac = '0;
      for (int i = 0; i < N; i++) begin
        fnd = 0;
        for (int off = 0; off < M; off++) begin
          idx = (m_a[i] + off) % M;
          if (!fnd && gn[idx][i]) begin ac[idx][i] = 1; fnd = 1; end
        end
      end
      if (k == 0)
        for (int j = 0; j < M; j++)
          for (int i = 0; i < N; i++)
            if (ac[j][i]) begin m_g[j] = (i + 1) % N; m_a[i] = (j + 1) % M; end
      res = res | ac;
`ifdef LIB_ALLOCATOR_EARLY_EXIT_EN
      alli = 1; allo = 1;
      for (int i = 0; i < N; i++) begin
        fnd = 0;
        for (int j = 0; j < M; j++) if (res[j][i]) fnd = 1;
        if (!fnd) alli = 0;
      end
      for (int j = 0; j < M; j++) if (res[j] == 4'b0) allo = 0;
      if (ac == '0 || alli || allo) begin lat = k + 2; break; end
`else
      alli = 0; allo = 0;
`endif
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; i_start = 1'b0; i_request = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int x = 0; x < 4; x++) begin m_g[x] = 0; m_a[x] = 0; end
    exp_q.delete(); lat_q.delete();
  endtask

  task automatic check_ptrs(input string name);
    for (int x = 0; x < 4; x++) begin
      n_cmp++;
      if (int'(dut.g_q[x]) !== m_g[x]) begin
        n_err++; $display("FAIL %s g[%0d]: got %0d want %0d", name, x, dut.g_q[x], m_g[x]);
      end
      n_cmp++;
      if (int'(dut.a_q[x]) !== m_a[x]) begin
        n_err++; $display("FAIL %s a[%0d]: got %0d want %0d", name, x, dut.a_q[x], m_a[x]);
      end
    end
  endtask

  // Pop the scoreboard on an o_valid pulse and compare grant, latency and matching invariants
  task automatic score_pulse(input int cyc, input string name, output mat_t e);
    int el, cnt;
    e = '0;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL %s unexpected o_valid at cycle %0d", name, cyc);
    end else begin
      e = exp_q.pop_front(); el = lat_q.pop_front();
      if (o_grant !== e) begin
        n_err++; $display("FAIL %s grant: got %b want %b", name, o_grant, e);
      end
      n_cmp++;
      if (cyc !== el) begin
        n_err++; $display("FAIL %s latency: got %0d want %0d", name, cyc, el);
      end
    end
    for (int j = 0; j < M; j++) begin
      n_cmp++;
      if (!$onehot0(o_grant[j])) begin
        n_err++; $display("FAIL %s out%0d not onehot0: got %b", name, j, o_grant[j]);
      end
    end
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      for (int j = 0; j < M; j++) if (o_grant[j][i] === 1'b1) cnt++;
      n_cmp++;
      if (cnt > 1) begin
        n_err++; $display("FAIL %s in%0d matched %0d times, want <=1", name, i, cnt);
      end
    end
  endtask

  task automatic run_one(input mat_t req, input string name, output int obs);
    mat_t e, got;
    int el, cyc;
    bit seen;
    model_match(req, e, el);
    exp_q.push_back(e); lat_q.push_back(el);
    i_request = req; i_start = 1'b1;
    cyc = 0; seen = 0; obs = -1; got = '0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        i_start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b want 1", name, o_busy); end
      end
      if (o_valid === 1'b1) begin seen = 1; obs = cyc; score_pulse(cyc, name, got); end
    end
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL %s timeout: no o_valid within 20 cycles", name);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL %s after pulse valid/busy: got %b%b want 00", name, o_valid, o_busy);
    end
    n_cmp++;
    if (o_grant !== e) begin n_err++; $display("FAIL %s hold: got %b want %b", name, o_grant, e); end
    check_ptrs(name);
  endtask

  function automatic mat_t ident();
    mat_t r;
    r = '0;
    for (int x = 0; x < 4; x++) r[x][x] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; #1;
    n_cmp++;
    if (o_grant !== '0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL reset outputs: got %b %b %b want 0 0 0", o_grant, o_valid, o_busy);
    end
    apply_reset();
    check_ptrs("reset");
  endtask

  task automatic test_identity();
    int obs, want_lat;
    mat_t want;
    apply_reset();
    run_one(ident(), "identity", obs);
    want = ident();
`ifdef LIB_ALLOCATOR_EARLY_EXIT_EN
    want_lat = 2;
`else
    want_lat = ITERS + 1;
`endif
    n_cmp++;
    if (obs !== want_lat) begin n_err++; $display("FAIL identity_lat: got %0d want %0d", obs, want_lat); end
    n_cmp++;
    if (o_grant !== want) begin n_err++; $display("FAIL identity_const: got %b want %b", o_grant, want); end
    for (int x = 0; x < 4; x++) begin
      n_cmp++;
      if (int'(dut.g_q[x]) !== (x + 1) % 4 || int'(dut.a_q[x]) !== (x + 1) % 4) begin
        n_err++; $display("FAIL identity_ptr%0d: got g=%0d a=%0d want %0d", x, dut.g_q[x], dut.a_q[x], (x + 1) % 4);
      end
    end
  endtask

  task automatic test_all_request();
    int obs, pairs;
    mat_t all1, want1;
    apply_reset();
    all1 = '1;
    want1 = '0; want1[0][0] = 1'b1; want1[1][1] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      run_one(all1, "all_req", obs);
      if (s == 0) begin
        n_cmp++;
        if (o_grant !== want1) begin n_err++; $display("FAIL all_req_s1: got %b want %b", o_grant, want1); end
      end
    end
    pairs = 0;
    for (int j = 0; j < M; j++) for (int i = 0; i < N; i++) if (o_grant[j][i] === 1'b1) pairs++;
    n_cmp++;
    if (pairs !== 4) begin n_err++; $display("FAIL all_req_s4_pairs: got %0d want 4", pairs); end
  endtask

  task automatic test_contention();
    int obs;
    mat_t req;
    int want_in[3] = '{0, 1, 0};
    int want_g2[3] = '{1, 2, 1};
    apply_reset();
    req = '0; req[0][2] = 1'b1; req[1][2] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      run_one(req, "contend", obs);
      n_cmp++;
      if (o_grant[2] !== (4'b0001 << want_in[s]) || o_grant[0] !== 4'b0 || o_grant[1] !== 4'b0 || o_grant[3] !== 4'b0) begin
        n_err++; $display("FAIL contend_s%0d: got %b want out2->in%0d", s, o_grant, want_in[s]);
      end
      n_cmp++;
      if (int'(dut.g_q[2]) !== want_g2[s] || dut.g_q[0] !== 2'd0 || dut.g_q[1] !== 2'd0 || dut.g_q[3] !== 2'd0) begin
        n_err++; $display("FAIL contend_g_s%0d: got g2=%0d want %0d", s, dut.g_q[2], want_g2[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mat_t ra, rb, e, got;
    int pl[3];
    int el, pulses;
    apply_reset();
    ra = ident();
    rb = '0;
    for (int x = 0; x < 4; x++) rb[x][3 - x] = 1'b1;
    model_match(ra, e, el); exp_q.push_back(e); lat_q.push_back(el); pl[0] = el;
    model_match(rb, e, el); exp_q.push_back(e); lat_q.push_back(el); pl[1] = pl[0] + 1 + el;
    model_match(rb, e, el); exp_q.push_back(e); lat_q.push_back(el); pl[2] = pl[1] + 1 + el;
    i_request = ra; i_start = 1'b1; pulses = 0;
    for (int cyc = 1; cyc <= pl[2] + 1; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) i_request = rb;
      if (o_valid === 1'b1) begin
        pulses++;
        n_cmp++;
        if (pulses > 3 || cyc !== pl[pulses - 1]) begin
          n_err++; $display("FAIL b2b_pulse%0d: got cycle %0d", pulses, cyc);
        end else begin
          score_pulse(cyc - (pulses == 1 ? 0 : pl[pulses - 2] + 1), "b2b", got);
        end
      end
    end
    i_start = 1'b0;
    n_cmp++;
    if (pulses !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", pulses); end
    @(posedge clk); #1;
    check_ptrs("b2b");
  endtask

  task automatic test_reset_mid();
    int obs;
    bit pulsed;
    apply_reset();
    run_one(ident(), "pre_abort", obs);
    i_request = ident(); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    pulsed = 0;
    reset_n = 1'b0; #1;
    n_cmp++;
    if (o_grant !== '0 || o_busy !== 1'b0 || dut.g_q !== '0 || dut.a_q !== '0) begin
      n_err++; $display("FAIL abort_state: got grant %b busy %b g %b a %b want all 0", o_grant, o_busy, dut.g_q, dut.a_q);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) reset_n = 1'b1;
      if (o_valid === 1'b1) pulsed = 1;
    end
    n_cmp++;
    if (pulsed) begin n_err++; $display("FAIL abort_valid: got pulse want none"); end
    for (int x = 0; x < 4; x++) begin m_g[x] = 0; m_a[x] = 0; end
    exp_q.delete(); lat_q.delete();
    run_one(ident(), "post_abort", obs);
    n_cmp++;
    if (o_grant !== ident()) begin n_err++; $display("FAIL post_abort_const: got %b want %b", o_grant, ident()); end
  endtask

  task automatic test_zero_request();
    int obs, want_lat;
    apply_reset();
    run_one(ident(), "zero_pre", obs);
    run_one('0, "zero_req", obs);
`ifdef LIB_ALLOCATOR_EARLY_EXIT_EN
    want_lat = 2;
`else
    want_lat = ITERS + 1;
`endif
    n_cmp++;
    if (obs !== want_lat || o_grant !== '0) begin
      n_err++; $display("FAIL zero_req: got lat %0d grant %b want lat %0d grant 0", obs, o_grant, want_lat);
    end
    for (int x = 0; x < 4; x++) begin
      n_cmp++;
      if (int'(dut.g_q[x]) !== (x + 1) % 4) begin
        n_err++; $display("FAIL zero_ptr%0d: got %0d want %0d", x, dut.g_q[x], (x + 1) % 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_request();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_zero_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
